// File: rtl/sara_pkg.sv
// Shared definitions for the SARA_DAR adder family: recovery FSM encoding,
// segment-count helper and the speculative window carry used by adder and recovery.
package sara_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SPEC_MAXW = 32;

    function automatic int nseg(input int size, input int groupsize);
        return size / groupsize;
    endfunction

    // Carry out of the low 'win' bits of the operands with carry-in 0; bits above win ignored.
    function automatic logic spec_carry(input logic [SPEC_MAXW-1:0] a_win,
                                        input logic [SPEC_MAXW-1:0] b_win,
                                        input int                   win);
        logic c;
        c = 1'b0;
        for (int i = 0; i < SPEC_MAXW; i++) begin
            if (i < win) begin
                c = (a_win[i] & b_win[i]) | (c & (a_win[i] ^ b_win[i]));
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sara_seg_fix.sv
// Combinational exact add of one segment, plus the speculative carry the
// approximate adder would have produced out of this segment's top window.
module sara_seg_fix
    import sara_pkg::*;
#(
    parameter int GROUPSIZE = 8,
    parameter int WINDOW    = 2
) (
    input  logic [GROUPSIZE-1:0] a_k,
    input  logic [GROUPSIZE-1:0] b_k,
    input  logic                 c_in,
    output logic [GROUPSIZE-1:0] sum_k,
    output logic                 c_out,
    output logic                 spec_out
);

    logic [GROUPSIZE:0]   full_sum;
    logic [SPEC_MAXW-1:0] a_win;
    logic [SPEC_MAXW-1:0] b_win;

    always_comb begin
        full_sum = {1'b0, a_k} + {1'b0, b_k} + {{GROUPSIZE{1'b0}}, c_in};
        a_win    = '0;
        b_win    = '0;
        a_win[WINDOW-1:0] = a_k[GROUPSIZE-1 -: WINDOW];
        b_win[WINDOW-1:0] = b_k[GROUPSIZE-1 -: WINDOW];
    end

    assign sum_k    = full_sum[GROUPSIZE-1:0];
    assign c_out    = full_sum[GROUPSIZE];
    assign spec_out = spec_carry(a_win, b_win, WINDOW);

endmodule

// File: rtl/sara_dar_err_recovery.sv
// Recovery stage for the SARA_DAR approximate adder: walks segment carries one per
// cycle and rewrites mis-speculated segments. Define SARA_ERR_CNT_EN to add err_cnt.
module sara_dar_err_recovery
    import sara_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 8,
    parameter int WINDOW    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    input  logic [SIZE-1:0] sum_appx,
    input  logic            cout_appx,
    input  logic            acc_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] sum_out,
    output logic            cout_out,
    output logic            err_flag
`ifdef SARA_ERR_CNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);

    localparam int NSEG = nseg(SIZE, GROUPSIZE);
    localparam int KW   = (NSEG > 2) ? $clog2(NSEG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

    state_t              state_reg;
    state_t              state_next;
    logic                ready_reg;
    logic [KW-1:0]       k_reg;
    logic [SIZE-1:0]     a_reg;
    logic [SIZE-1:0]     b_reg;
    logic [SIZE-1:0]     sum_reg;
    logic                cout_reg;
    logic                err_reg;
    logic                carry_reg;
    logic                spec_reg;

    logic [GROUPSIZE-1:0] a_seg   [NSEG];
    logic [GROUPSIZE-1:0] b_seg   [NSEG];
    logic [GROUPSIZE-1:0] sum_seg [NSEG];

    logic [GROUPSIZE-1:0] fix_a;
    logic [GROUPSIZE-1:0] fix_b;
    logic                 fix_cin;
    logic [GROUPSIZE-1:0] fix_sum;
    logic                 fix_cout;
    logic                 fix_spec;

    logic accept;
    logic seg_wrong;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign a_seg[gi]   = a_reg[gi*GROUPSIZE +: GROUPSIZE];
            assign b_seg[gi]   = b_reg[gi*GROUPSIZE +: GROUPSIZE];
            assign sum_seg[gi] = sum_reg[gi*GROUPSIZE +: GROUPSIZE];
        end
    endgenerate

    // In IDLE the adder looks at segment 0 of the live inputs so that c_1/spec_1
    // are ready at capture; in FIX it looks at captured segment k.
    always_comb begin
        if (state_reg == S_IDLE) begin
            fix_a   = a[GROUPSIZE-1:0];
            fix_b   = b[GROUPSIZE-1:0];
            fix_cin = cin;
        end else begin
            fix_a   = a_seg[k_reg];
            fix_b   = b_seg[k_reg];
            fix_cin = carry_reg;
        end
    end

    sara_seg_fix #(
        .GROUPSIZE (GROUPSIZE),
        .WINDOW    (WINDOW)
    ) u_seg_fix (
        .a_k      (fix_a),
        .b_k      (fix_b),
        .c_in     (fix_cin),
        .sum_k    (fix_sum),
        .c_out    (fix_cout),
        .spec_out (fix_spec)
    );

    assign accept    = (state_reg == S_IDLE) && in_valid && ready_reg;
    assign seg_wrong = (carry_reg != spec_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = acc_mode ? S_FIX : S_DONE;
                end
            end
            S_FIX: begin
                if (k_reg == K_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            carry_reg <= 1'b0;
            spec_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sum_reg   <= sum_appx;
                        cout_reg  <= cout_appx;
                        err_reg   <= 1'b0;
                        k_reg     <= KW'(1);
                        carry_reg <= fix_cout;
                        spec_reg  <= fix_spec;
                    end
                end
                S_FIX: begin
                    if (seg_wrong) begin
                        sum_reg[int'(k_reg)*GROUPSIZE +: GROUPSIZE] <= fix_sum;
                        if (fix_sum != sum_seg[k_reg]) begin
                            err_reg <= 1'b1;
                        end
                    end
                    // Exact carry chain continues from the corrected segment.
                    carry_reg <= fix_cout;
                    spec_reg  <= fix_spec;
                    k_reg     <= k_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        cout_reg <= fix_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SARA_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((state_reg == S_DONE) && out_ready && err_reg && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

    assign in_ready  = ready_reg;
    assign out_valid = (state_reg == S_DONE);
    assign sum_out   = sum_reg;
    assign cout_out  = cout_reg;
    assign err_flag  = err_reg;

endmodule

// File: tb/tb_sara_dar_err_recovery.sv
// Scoreboard bench for sara_dar_err_recovery at SIZE=16, GROUPSIZE=8, WINDOW=2;
// directed vectors with hand-computed exact/approximate results.
module tb_sara_dar_err_recovery;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sa;
        logic        ca;
        logic        acc;
        logic [15:0] es;
        logic        ec;
        logic        ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum_appx;
    logic        cout_appx;
    logic        acc_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_out;
    logic        cout_out;
    logic        err_flag;
`ifdef SARA_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   exp_cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    sara_dar_err_recovery #(
        .SIZE      (16),
        .GROUPSIZE (8),
        .WINDOW    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum_appx  (sum_appx),
        .cout_appx (cout_appx),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .err_flag  (err_flag)
`ifdef SARA_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops one expectation per presented result, then checks it stays stable.
    initial begin
        exp_t cur;
        bit   seen;
        int   txn;
        seen = 0;
        txn  = 0;
        cur  = '{sum: 16'h0, cout: 1'b0, err: 1'b0, lat: 0, acc_cyc: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
                        cur = '{sum: sum_out, cout: cout_out, err: err_flag, lat: 0, acc_cyc: cyc};
                    end else begin
                        cur = q.pop_front();
                        txn++;
                        $display("txn %0d: sum_out=%04h cout_out=%0b err_flag=%0b latency=%0d (exp %04h %0b %0b %0d)",
                                 txn, sum_out, cout_out, err_flag, cyc - cur.acc_cyc + 1,
                                 cur.sum, cur.cout, cur.err, cur.lat);
                        chk("sum_out", 32'(sum_out), 32'(cur.sum));
                        chk("cout_out", 32'(cout_out), 32'(cur.cout));
                        chk("err_flag", 32'(err_flag), 32'(cur.err));
                        chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
                    end
                end else begin
                    chk("sum_hold", 32'(sum_out), 32'(cur.sum));
                    chk("cout_hold", 32'(cout_out), 32'(cur.cout));
                end
                chk("in_ready_busy", 32'(in_ready), 32'(0));
                if (out_ready) begin
                    seen = 0;
                    if (cur.err) exp_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic issue(input vec_t v);
        int   t;
        exp_t e;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sum_appx  = v.sa;
        cout_appx = v.ca;
        acc_mode  = v.acc;
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = '{sum: v.es, cout: v.ec, err: v.ee, lat: (v.acc ? 2 : 1), acc_cyc: cyc};
        q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("drain_timeout", 32'(q.size() != 0 || out_valid), 32'(0));
    endtask

    vec_t vecs[$];
    vec_t v3;
    vec_t v5;
    int   base;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sum_appx  = '0;
        cout_appx = 1'b0;
        acc_mode  = 1'b0;

        v3 = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sa: 16'h0000, ca: 1'b0, acc: 1'b1,
               es: 16'h0100, ec: 1'b0, ee: 1'b1};
        v5 = '{a: 16'hF1E0, b: 16'hF000, cin: 1'b0, sa: 16'hE1E0, ca: 1'b0, acc: 1'b1,
               es: 16'hE1E0, ec: 1'b1, ee: 1'b0};
        vecs.push_back('{a: 16'h01E8, b: 16'h005F, cin: 1'b0, sa: 16'h0247, ca: 1'b0, acc: 1'b1,
                         es: 16'h0247, ec: 1'b0, ee: 1'b0});
        vecs.push_back(v3);
        vecs.push_back('{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sa: 16'h0000, ca: 1'b0, acc: 1'b0,
                         es: 16'h0000, ec: 1'b0, ee: 1'b0});
        vecs.push_back('{a: 16'h12FF, b: 16'h3400, cin: 1'b1, sa: 16'h4600, ca: 1'b0, acc: 1'b1,
                         es: 16'h4700, ec: 1'b0, ee: 1'b1});
        vecs.push_back('{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sa: 16'hFF00, ca: 1'b0, acc: 1'b1,
                         es: 16'h0000, ec: 1'b1, ee: 1'b1});
        vecs.push_back('{a: 16'h7F80, b: 16'h0080, cin: 1'b0, sa: 16'h8000, ca: 1'b0, acc: 1'b1,
                         es: 16'h8000, ec: 1'b0, ee: 1'b0});
        vecs.push_back('{a: 16'h1234, b: 16'h5678, cin: 1'b0, sa: 16'hBEEF, ca: 1'b1, acc: 1'b0,
                         es: 16'hBEEF, ec: 1'b1, ee: 1'b0});

        // Power-on reset
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum_out", 32'(sum_out), 32'(0));
        chk("rst_cout_out", 32'(cout_out), 32'(0));
        chk("rst_err_flag", 32'(err_flag), 32'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", 32'(in_ready), 32'(1));
        #1;

        // Reset while the stage is in FIX
        a = 16'h01E8; b = 16'h005F; cin = 1'b0; sum_appx = 16'h0247; cout_appx = 1'b1; acc_mode = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midfix_out_valid", 32'(out_valid), 32'(0));
        chk("midfix_sum_out", 32'(sum_out), 32'(0));
        chk("midfix_cout_out", 32'(cout_out), 32'(0));
        chk("midfix_err_flag", 32'(err_flag), 32'(0));
        chk("midfix_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midfix_ready_before_edge", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("midfix_ready_first_edge", 32'(in_ready), 32'(1));
        repeat (4) begin
            @(negedge clk);
            chk("no_partial_result", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #2;

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i]);
        end
        wait_idle();

        // Back-pressure: result held, second offer ignored
        out_ready = 1'b0;
        issue(v5);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sum_appx = 16'h0000; cout_appx = 1'b0; acc_mode = 1'b1;
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
            chk("stall_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;

`ifdef SARA_ERR_CNT_EN
        base = exp_cnt;
        chk("err_cnt_base", 32'(err_cnt), 32'(base));
        repeat (3) issue(v3);
        wait_idle();
        @(posedge clk);
        #2;
        chk("err_cnt_plus3", 32'(err_cnt), 32'(base + 3));
        issue(vecs[0]);
        wait_idle();
        @(posedge clk);
        #2;
        chk("err_cnt_unchanged", 32'(err_cnt), 32'(base + 3));
`else
        base = 0;
        repeat (3) issue(v3);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'(base * 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
